// File: rtl/bcd_seven_seg_scan.sv
// Latches a 3-digit BCD word and scans it onto a 4-digit common-anode 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (hundreds, then tens).
module bcd_seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2,
        SLOT_BLANK    = 2'd3
    } slot_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [3:0]       AN_OFF    = 4'b1111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            slot_q, slot_d;
    logic [11:0]      display_q, display_d;
    logic [11:0]      pending_q, pending_d;
    logic             pending_flag_q, pending_flag_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;
    logic             tick;
    logic             wrap;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments only; the async reset clears every register, including the data words, so the display never shows stale data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            slot_q         <= SLOT_ONES;
            display_q      <= 12'h000;
            pending_q      <= 12'h000;
            pending_flag_q <= 1'b0;
            seg_q          <= SEG_BLANK;
            an_q           <= AN_OFF;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            display_q      <= display_d;
            pending_q      <= pending_d;
            pending_flag_q <= pending_flag_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // NOTE: every signal driven here gets a hold/default value first so no latch is inferred.
    always_comb begin
        tick           = (cnt_q == CNT_MAX);
        cnt_d          = tick ? '0 : cnt_q + 1'b1;
        slot_d         = slot_q;
        wrap           = 1'b0;
        display_d      = display_q;
        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        seg_d          = seg_q;
        an_d           = an_q;

        if (tick) begin
            slot_d = slot_e'(slot_q + 2'd1);
            wrap   = (slot_q == SLOT_BLANK);
        end

        if (bcd_valid) begin
            pending_d      = bcd_in;
            pending_flag_d = 1'b1;
        end

        // A strobe landing on the wrap edge is newer than anything pending, so it goes straight to the display.
        if (wrap) begin
            if (bcd_valid) begin
                display_d = bcd_in;
            end else if (pending_flag_q) begin
                display_d = pending_q;
            end
            pending_flag_d = 1'b0;
        end

        if (tick) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            case (slot_d)
                SLOT_ONES: begin
                    an_d  = 4'b1110;
                    seg_d = decode(display_d[3:0]);
                end
                SLOT_TENS: begin
                    an_d  = 4'b1101;
                    seg_d = decode(display_d[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
                    if (display_d[11:4] == 8'h00) seg_d = SEG_BLANK;
`endif
                end
                SLOT_HUNDREDS: begin
                    an_d  = 4'b1011;
                    seg_d = decode(display_d[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
                    if (display_d[11:8] == 4'h0) seg_d = SEG_BLANK;
`endif
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
        end

        frame_done_d = wrap;
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = 1'b1;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Self-checking bench for bcd_seven_seg_scan with REFRESH_DIV=4; honours LEADING_ZERO_BLANK_EN.
module tb_bcd_seven_seg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        bcd_valid = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Model: edges since reset release, latest strobed value, value shown this frame.
    int          m_n     = 0;
    logic [11:0] m_last  = 12'h000;
    logic [11:0] m_shown = 12'h000;

    bcd_seven_seg_scan #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, m_n, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (nib > 4'd9) return 7'b0111111;
        return tbl[nib];
    endfunction

    // Expected {an, seg, dp, frame_done} after edge n with value v on display.
    function automatic logic [12:0] expect_out(input int n, input logic [11:0] v);
        logic [3:0] a;
        logic [6:0] s;
        logic       fd;
        int         slot;
        fd = (n > 0) && (n % FRAME == 0);
        a  = 4'b1111;
        s  = 7'b1111111;
        if (n >= DIV) begin
            slot = (n / DIV) % 4;
            if (slot == 0) begin
                a = 4'b1110; s = glyph(v[3:0]);
            end else if (slot == 1) begin
                a = 4'b1101; s = glyph(v[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
                if (v[11:8] == 4'd0 && v[7:4] == 4'd0) s = 7'b1111111;
`endif
            end else if (slot == 2) begin
                a = 4'b1011; s = glyph(v[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
                if (v[11:8] == 4'd0) s = 7'b1111111;
`endif
            end
        end
        return {a, s, 1'b1, fd};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [11:0] lv;
        if (rst) begin
            m_n     <= 0;
            m_last  <= 12'h000;
            m_shown <= 12'h000;
        end else begin
            lv = bcd_valid ? bcd_in : m_last;
            m_last <= lv;
            if ((m_n + 1) % FRAME == 0) m_shown <= lv;
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        check("scan", {19'b0, an, seg, dp, frame_done}, {19'b0, expect_out(m_n, m_shown)});
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (m_n != target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_n != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_edge: reached %0d, needed %0d", m_n, target);
        end
    endtask

    task automatic strobe(input logic [11:0] v);
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    task automatic pin(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        check({name, "_an"}, {28'b0, an}, {28'b0, exp_an});
        check({name, "_seg"}, {25'b0, seg}, {25'b0, exp_seg});
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        pin("reset", 4'b1111, 7'b1111111);
        check("reset_dp", {31'b0, dp}, 32'd1);
        check("reset_fd", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;

        wait_n(3);   pin("pre_tick", 4'b1111, 7'b1111111);
        wait_n(4);   pin("first_tick_tens0", 4'b1101, 7'b1000000);
        wait_n(16);  pin("first_ones0", 4'b1110, 7'b1000000);
        check("fd_pulse", {31'b0, frame_done}, 32'd1);
        wait_n(17);  check("fd_clear", {31'b0, frame_done}, 32'd0);

        wait_n(20);  strobe(12'h255);
        wait_n(28);  pin("no_early_update", 4'b1111, 7'b1111111);
        wait_n(32);  pin("v255_ones", 4'b1110, 7'b0010010);
        wait_n(36);  pin("v255_tens", 4'b1101, 7'b0010010);
        wait_n(40);  pin("v255_hund", 4'b1011, 7'b0100100);

        wait_n(50);  strobe(12'h123);
        wait_n(54);  strobe(12'h456);
        wait_n(64);  pin("last_wins_ones", 4'b1110, 7'b0000010);
        wait_n(68);  pin("last_wins_tens", 4'b1101, 7'b0010010);
        wait_n(72);  pin("last_wins_hund", 4'b1011, 7'b0011001);

        wait_n(95);  strobe(12'h789);
        wait_n(96);  pin("bypass_ones", 4'b1110, 7'b0010000);
        wait_n(100); pin("bypass_tens", 4'b1101, 7'b0000000);
        wait_n(104); pin("bypass_hund", 4'b1011, 7'b1111000);
        wait_n(112); pin("bypass_held", 4'b1110, 7'b0010000);

        wait_n(120); strobe(12'h0A5);
        wait_n(128); pin("inv_ones", 4'b1110, 7'b0010010);
        wait_n(132); pin("inv_tens_dash", 4'b1101, 7'b0111111);
        wait_n(136);
`ifdef LEADING_ZERO_BLANK_EN
        pin("inv_hund", 4'b1011, 7'b1111111);
`else
        pin("inv_hund", 4'b1011, 7'b1000000);
`endif

        wait_n(140); strobe(12'h007);
        wait_n(144); pin("v007_ones", 4'b1110, 7'b1111000);
`ifdef LEADING_ZERO_BLANK_EN
        wait_n(148); pin("v007_tens", 4'b1101, 7'b1111111);
        wait_n(152); pin("v007_hund", 4'b1011, 7'b1111111);
`else
        wait_n(148); pin("v007_tens", 4'b1101, 7'b1000000);
        wait_n(152); pin("v007_hund", 4'b1011, 7'b1000000);
`endif

        @(posedge clk);
        #2 rst = 1'b1;
        #1 pin("async_reset", 4'b1111, 7'b1111111);
        check("async_reset_fd", {31'b0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wait_n(3);   pin("rerelease_pre", 4'b1111, 7'b1111111);
`ifdef LEADING_ZERO_BLANK_EN
        wait_n(4);   pin("rerelease_tens", 4'b1101, 7'b1111111);
`else
        wait_n(4);   pin("rerelease_tens", 4'b1101, 7'b1000000);
`endif
        wait_n(16);  check("rerelease_fd", {31'b0, frame_done}, 32'd1);
        wait_n(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
